// File: rtl/aucohl_pgen_pkg.sv
// Shared types and default sizing for the pulse-train generator.
package aucohl_pgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pgen_state_e;

    localparam int DEF_CW = 16;
    localparam int DEF_PW = 8;

endpackage

// File: rtl/aucohl_pgen_prescaler.sv
// Prescaler: counts 0..pr and emits a one-cycle tick on the terminal count.
module aucohl_pgen_prescaler #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] pr,
    output logic          tick
);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == pr) ? '0 : cnt + PW'(1);
        end
    end

    assign tick = en && (cnt == pr);

endmodule

// File: rtl/aucohl_pulse_gen16.sv
// Programmable pulse-train generator: high/low widths in prescaled ticks,
// finite or continuous number of periods, with abort and output invert.
module aucohl_pulse_gen16
    import aucohl_pgen_pkg::*;
#(
    parameter int CW = DEF_CW,
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          stop,
    input  logic [PW-1:0] pr,
    input  logic [CW-1:0] hi_len,
    input  logic [CW-1:0] lo_len,
    input  logic [CW-1:0] count,
    input  logic          inv,
    output logic          ext_out,
    output logic          busy,
    output logic          done,
    output logic          period_tick
);

    localparam logic [CW-1:0] ONE = CW'(1);

    pgen_state_e   state;
    logic [PW-1:0] pr_s;
    logic [CW-1:0] hi_s, lo_s, count_s;
    logic [CW-1:0] wcnt, pcnt;
    logic          ext_q;
    logic          tick;

    logic          go, abort;
    logic [CW-1:0] hi_eff, lo_eff, pnext;

    assign go     = start && en && !stop;
    assign abort  = stop || !en;
    assign hi_eff = (hi_s == '0) ? ONE : hi_s;
    assign lo_eff = (lo_s == '0) ? ONE : lo_s;
    assign pnext  = pcnt + ONE;

    // Prescaler restarts with the train so the first tick lands pr_s+1 clocks in.
    aucohl_pgen_prescaler #(
        .PW (PW)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == IDLE && go) || !en),
        .en   (state != IDLE),
        .pr   (pr_s),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pr_s        <= '0;
            hi_s        <= '0;
            lo_s        <= '0;
            count_s     <= '0;
            wcnt        <= '0;
            pcnt        <= '0;
            ext_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            done        <= 1'b0;
            period_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        pr_s    <= pr;
                        hi_s    <= hi_len;
                        lo_s    <= lo_len;
                        count_s <= count;
                        wcnt    <= ONE;
                        pcnt    <= '0;
                        state   <= HIGH;
                        ext_q   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                HIGH: begin
                    if (abort) begin
                        state <= IDLE;
                        ext_q <= 1'b0;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        if (wcnt == hi_eff) begin
                            state <= LOW;
                            ext_q <= 1'b0;
                            wcnt  <= ONE;
                        end else begin
                            wcnt <= wcnt + ONE;
                        end
                    end
                end
                LOW: begin
                    if (abort) begin
                        state <= IDLE;
                        ext_q <= 1'b0;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        if (wcnt == lo_eff) begin
                            period_tick <= 1'b1;
                            pcnt        <= pnext;
                            if (count_s != '0 && pnext == count_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= HIGH;
                                ext_q <= 1'b1;
                                wcnt  <= ONE;
                            end
                        end else begin
                            wcnt <= wcnt + ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    ext_q <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ext_out = ext_q ^ inv;

endmodule

// File: tb/tb_aucohl_pulse_gen16.sv
// Directed bench for aucohl_pulse_gen16: phase lengths, completion, abort, reset, invert.
module tb_aucohl_pulse_gen16;

    logic        clk = 1'b0;
    logic        rst, en, start, stop, inv;
    logic [7:0]  pr;
    logic [15:0] hi_len, lo_len, count;
    logic        ext_out, busy, done, period_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int pt_cnt   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    aucohl_pulse_gen16 #(.CW(16), .PW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .stop        (stop),
        .pr          (pr),
        .hi_len      (hi_len),
        .lo_len      (lo_len),
        .count       (count),
        .inv         (inv),
        .ext_out     (ext_out),
        .busy        (busy),
        .done        (done),
        .period_tick (period_tick)
    );

    // Pulses are counted at the edge that ends their cycle.
    always @(posedge clk) begin
        if (period_tick) pt_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_start(input int p, input int h, input int l, input int c);
        pr     = 8'(p);
        hi_len = 16'(h);
        lo_len = 16'(l);
        count  = 16'(c);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts consecutive cycles the output holds its current level while busy.
    task automatic run_phase(output int n);
        logic lvl;
        lvl = ext_out;
        n = 0;
        while (busy === 1'b1 && ext_out === lvl && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n, pt0, d0, total;

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; inv = 1'b0;
        pr = '0; hi_len = '0; lo_len = '0; count = '0;
        step(3);
        check("rst_ext", 32'(ext_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pt", 32'(period_tick), 0);
        rst = 1'b0;
        step(2);

        // Basic finite train: 15 high / 10 low, twice
        pt0 = pt_cnt; d0 = done_cnt;
        do_start(4, 3, 2, 2);
        check("t1_busy", 32'(busy), 1);
        check("t1_rise", 32'(ext_out), 1);
        total = 0;
        run_phase(n); total += n; check("t1_hi1", 32'(n), 15);
        run_phase(n); total += n; check("t1_lo1", 32'(n), 10);
        check("t1_pt1", 32'(period_tick), 1);
        check("t1_done_early", 32'(done), 0);
        run_phase(n); total += n; check("t1_hi2", 32'(n), 15);
        run_phase(n); total += n; check("t1_lo2", 32'(n), 10);
        check("t1_total", 32'(total), 50);
        check("t1_done", 32'(done), 1);
        check("t1_pt2", 32'(period_tick), 1);
        check("t1_busy_end", 32'(busy), 0);
        step(1);
        check("t1_done_pulse", 32'(done), 0);
        check("t1_pt_count", 32'(pt_cnt - pt0), 2);
        check("t1_done_count", 32'(done_cnt - d0), 1);

        // Zero widths behave as one tick each
        do_start(0, 0, 0, 3);
        total = 0;
        for (int k = 0; k < 3; k++) begin
            run_phase(n); total += n; check("t2_hi", 32'(n), 1);
            run_phase(n); total += n; check("t2_lo", 32'(n), 1);
        end
        check("t2_total", 32'(total), 6);
        check("t2_done", 32'(done), 1);
        check("t2_busy", 32'(busy), 0);
        step(2);

        // Continuous train, then abort mid-HIGH
        pt0 = pt_cnt; d0 = done_cnt;
        do_start(1, 5, 5, 0);
        for (int k = 0; k < 11; k++) begin
            run_phase(n); check("t3_hi", 32'(n), 10);
            run_phase(n); check("t3_lo", 32'(n), 10);
        end
        check("t3_still_busy", 32'(busy), 1);
        step(3);
        check("t3_mid_high", 32'(ext_out), 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("t3_abort_ext", 32'(ext_out), 0);
        check("t3_abort_busy", 32'(busy), 0);
        check("t3_abort_done", 32'(done), 0);
        step(5);
        check("t3_pt_count", 32'(pt_cnt - pt0), 11);
        check("t3_no_done", 32'(done_cnt - d0), 0);

        // Start while busy ignored; config change mid-train ignored
        do_start(0, 2, 3, 1);
        hi_len = 16'd7;
        start = 1'b1;
        run_phase(n); check("t4_hi_unchanged", 32'(n), 2);
        start = 1'b0;
        run_phase(n); check("t4_lo", 32'(n), 3);
        check("t4_done", 32'(done), 1);
        step(1);
        // start with stop in IDLE stays idle
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        check("t4_ss_busy", 32'(busy), 0);
        check("t4_ss_ext", 32'(ext_out), 0);
        step(1);
        do_start(0, 7, 1, 1);
        run_phase(n); check("t4_new_hi", 32'(n), 7);
        run_phase(n); check("t4_new_lo", 32'(n), 1);

        // Reset during LOW, then a clean train
        step(1);
        do_start(0, 2, 4, 0);
        run_phase(n); check("t5_hi", 32'(n), 2);
        step(1);
        rst = 1'b1;
        step(1);
        check("t5_rst_ext", 32'(ext_out), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_pt", 32'(period_tick), 0);
        rst = 1'b0;
        step(1);
        do_start(2, 2, 1, 1);
        run_phase(n); check("t5_hi_after", 32'(n), 6);
        run_phase(n); check("t5_lo_after", 32'(n), 3);
        check("t5_done", 32'(done), 1);

        // Inverted polarity and rise-to-rise period in ticks
        inv = 1'b1;
        step(1);
        check("t6_idle_inv", 32'(ext_out), 1);
        do_start(4, 4, 6, 2);
        check("t6_active_low", 32'(ext_out), 0);
        total = 0;
        run_phase(n); total += n; check("t6_hi", 32'(n), 20);
        run_phase(n); total += n; check("t6_lo", 32'(n), 30);
        check("t6_period_ticks", 32'(total / 5), 10);
        run_phase(n);
        run_phase(n);
        check("t6_done", 32'(done), 1);
        check("t6_end_level", 32'(ext_out), 1);

        // en low aborts a running train
        inv = 1'b0;
        step(1);
        do_start(0, 3, 3, 0);
        step(1);
        en = 1'b0;
        step(1);
        check("t7_en_busy", 32'(busy), 0);
        check("t7_en_ext", 32'(ext_out), 0);
        en = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aucohl_pulse_gen16.md
# aucohl_pulse_gen16

Programmable pulse-train generator: the transmit-side counterpart of the 16-bit capture/compare counter. It drives a single output with programmed high and low widths, counted in prescaled clock ticks, for a programmed number of periods or continuously. It sits behind the same bus-wrapper/register scheme as the capture counter. Its output can be looped into the counter's `ext_in` for self-test.

## Interface
Parameters:
- `CW`, 16: width of the width and count registers.
- `PW`, 8: prescaler width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: block enable. Low forces IDLE and clears the prescaler.
- `start` in 1: one-cycle request to begin a train. Honoured only in IDLE with `en=1`.
- `stop` in 1: one-cycle abort.
- `pr` in PW: prescaler. One tick every `pr+1` clocks.
- `hi_len` in CW: high width in ticks. 0 is treated as 1.
- `lo_len` in CW: low width in ticks. 0 is treated as 1.
- `count` in CW: number of periods. 0 means continuous.
- `inv` in 1: output polarity invert. Applied combinationally at the output.
- `ext_out` out 1: pulse output. Registered before the `inv` XOR.
- `busy` out 1: high in states HIGH and LOW.
- `done` out 1: one-cycle pulse when a finite train completes.
- `period_tick` out 1: one-cycle pulse at the end of every completed period.

## Operation
- **FSM states:** IDLE, HIGH, LOW.
- **IDLE → HIGH on `start & en & ~stop`.** On this transition:
  - latch `pr`, `hi_len`, `lo_len`, `count` into shadow registers;
  - clear the prescaler, width counter and period counter.
- **Config changes while busy** have no effect until the next start.
- **Prescaler:**
  - counts 0..pr_s, wrapping to 0;
  - `tick` asserts on the cycle the prescaler equals pr_s.
- **Width counter:**
  - loaded with 1 on entry to HIGH or LOW, incremented on each `tick`;
  - HIGH → LOW on the tick where width count = max(hi_len_s,1);
  - LOW → HIGH on the tick where width count = max(lo_len_s,1);
  - at LOW → HIGH, `period_tick` pulses and the period counter increments (CW bits, wraps in continuous mode).
- **Finite completion:** if `count_s≠0` and the incremented period count equals `count_s`, the FSM goes LOW → IDLE instead of LOW → HIGH. On that transition `done` pulses and `period_tick` also pulses.
- **Abort:** `stop` or `~en` in any state → IDLE on the next edge. `ext_out` goes to 0 and no `done` pulse is issued. A `stop` arriving on the same cycle as `start` wins.
- **Start while busy** is ignored.
- **`rst`** overrides everything:
  - state IDLE;
  - all counters and shadows cleared;
  - `ext_out=0`, `busy=0`, `done=0`, `period_tick=0`.

## Timing
- **`start` sampled at edge N:** `busy=1` and `ext_out=1` from edge N+1.
- **Pulse widths in clock cycles:**
  - high phase = max(hi_len,1)·(pr+1);
  - low phase = max(lo_len,1)·(pr+1);
  - exact; the period has no extra cycles.
- **Completion:** `done` and `period_tick` are high for the cycle following the last low clock. `busy` falls on the same edge. A new `start` is accepted on that same cycle.
- **Abort:** `stop` sampled at edge N gives `ext_out=0` and `busy=0` after edge N+1 is registered.
- **Arithmetic:** all compares are unsigned. Maximum width is 65535·256 clocks; the counters must not overflow at this value.

## Structure
- **Package `aucohl_pgen_pkg`:**
  - state enum (IDLE=2'd0, HIGH=2'd1, LOW=2'd2);
  - default `CW`/`PW` constants.
- **Sub-module `aucohl_pgen_prescaler`:**
  - inputs: `clk`, `rst`, `clr`, `en`, `pr`;
  - output: `tick`;
  - shared in style with the capture counter's prescaler.
- **Top:** FSM, width counter, period counter, shadows, output register.

## Test plan
- **Basic finite train:** `pr=4`, `hi_len=3`, `lo_len=2`, `count=2`, `start` → `ext_out` high 15 clk, low 10 clk, repeated twice; `done` exactly 50 clk after the first rise; `period_tick` ×2.
- **Zero widths:** `pr=0`, `hi_len=0`, `lo_len=0`, `count=3` → 1-clk high / 1-clk low toggling for 6 clk, then `done`, `busy=0`.
- **Continuous with abort:** `count=0`, `pr=1`, `hi_len=5`, `lo_len=5` → runs past 10 periods; `stop` mid-HIGH → `ext_out=0` next cycle, no `done`.
- **Start rules:**
  - `start` while busy → ignored, waveform unchanged;
  - `start` together with `stop` in IDLE → stays IDLE;
  - changing `hi_len` mid-train → no effect until the next start.
- **Reset mid-operation:** `rst` asserted during LOW → all outputs 0 on the next edge; a fresh `start` after release gives a correct first period.
- **Loopback:** `inv=1` → idle level 1. Loopback into the capture counter in pos-to-pos period mode with `hi_len=4`, `lo_len=6`, `pr=4` → measured period matches 10 ticks.
